da3_serial_tx: RTL and testbench



---
 rtl/da3_serial_tx.sv | 133 +++++++++++++
 tb/tb_da3_serial_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/da3_serial_tx.sv
// PmodDA3 (AD5541) serial transmitter: accepts a 16-bit word on dacdav/davdac and shifts it MSB-first.
// Define DA3_LDAC_PULSE_EN to add an LDAC low pulse after each frame; otherwise dacld is tied low.
module da3_serial_tx #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dacdav,
  input  logic [15:0] dacdata,
  output logic        davdac,
  output logic        dacout,
  output logic        dacsck,
  output logic        daccs,
  output logic        dacld
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SHIFT  = 3'd2,
    S_HOLD   = 3'd3,
    S_CSHIGH = 3'd4
`ifdef DA3_LDAC_PULSE_EN
    , S_LDLOW = 3'd5
`endif
  } state_e;

`ifdef DA3_LDAC_PULSE_EN
  localparam logic LD_IDLE = 1'b1;
`else
  localparam logic LD_IDLE = 1'b0;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_e      state_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_q;
  logic [15:0] shreg_q;
  logic        davdac_q;
  logic        dacout_q;
  logic        dacsck_q;
  logic        daccs_q;
  logic        dacld_q;
  logic        div_last_s;

  assign div_last_s = (div_q == DIV_LAST);

  assign davdac = davdac_q;
  assign dacout = dacout_q;
  assign dacsck = dacsck_q;
  assign daccs  = daccs_q;
  assign dacld  = dacld_q;

  // Frame sequencer; every state except IDLE lasts whole multiples of CLKDIV cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      div_q    <= 8'd0;
      bit_q    <= 5'd0;
      shreg_q  <= 16'd0;
      davdac_q <= 1'b0;
      dacout_q <= 1'b0;
      dacsck_q <= 1'b0;
      daccs_q  <= 1'b1;
      dacld_q  <= LD_IDLE;
    end else begin
      davdac_q <= 1'b0;
      div_q    <= ((state_q == S_IDLE) || div_last_s) ? 8'd0 : div_q + 8'd1;
      case (state_q)
        S_IDLE: begin
          if (dacdav) begin
            shreg_q  <= dacdata;
            davdac_q <= 1'b1;
            daccs_q  <= 1'b0;
            dacout_q <= dacdata[15];
            bit_q    <= 5'd0;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (div_last_s) state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // Low phase ends in a rising SCLK; high phase ends in a falling SCLK plus a shift.
          if (div_last_s) begin
            if (!dacsck_q) begin
              dacsck_q <= 1'b1;
            end else begin
              dacsck_q <= 1'b0;
              if (bit_q == 5'd15) begin
                state_q <= S_HOLD;
              end else begin
                shreg_q  <= shreg_q << 5'd1;
                dacout_q <= shreg_q[14];
                bit_q    <= bit_q + 5'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (div_last_s) begin
            daccs_q <= 1'b1;
            state_q <= S_CSHIGH;
          end
        end
        S_CSHIGH: begin
          if (div_last_s) begin
`ifdef DA3_LDAC_PULSE_EN
            dacld_q <= 1'b0;
            state_q <= S_LDLOW;
`else
            state_q <= S_IDLE;
`endif
          end
        end
`ifdef DA3_LDAC_PULSE_EN
        S_LDLOW: begin
          if (div_last_s) begin
            dacld_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
`endif
        default: begin
          state_q  <= S_IDLE;
          daccs_q  <= 1'b1;
          dacsck_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_da3_serial_tx.sv
// Self-checking bench for da3_serial_tx: vector table, handshake, stuck dacdav, mid-frame reset, CLKDIV=1.
`timescale 1ns/1ps
module tb_da3_serial_tx;
  localparam int D0 = 2;
  localparam int D1 = 1;
`ifdef DA3_LDAC_PULSE_EN
  localparam logic LD_IDLE = 1'b1;
  localparam int   LDC     = 1;
`else
  localparam logic LD_IDLE = 1'b0;
  localparam int   LDC     = 0;
`endif
  localparam int FRAME0 = (35 + LDC) * D0;
  localparam int FRAME1 = (35 + LDC) * D1;

  logic clk = 1'b0;
  logic rst, dav, dav1;
  logic [15:0] data, data1;
  logic davdac, dacout, dacsck, daccs, dacld;
  logic davdac1, dacout1, dacsck1, daccs1, dacld1;

  always #5 clk = ~clk;

  da3_serial_tx #(.CLKDIV(D0)) u_dut (
    .CLK(clk), .RST(rst), .dacdav(dav), .dacdata(data),
    .davdac(davdac), .dacout(dacout), .dacsck(dacsck), .daccs(daccs), .dacld(dacld)
  );

  da3_serial_tx #(.CLKDIV(D1)) u_dut1 (
    .CLK(clk), .RST(rst), .dacdav(dav1), .dacdata(data1),
    .davdac(davdac1), .dacout(dacout1), .dacsck(dacsck1), .daccs(daccs1), .dacld(dacld1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          gap_q[$];

  int cyc = 0;
  logic sck_p = 1'b0, cs_p = 1'b1, dav_p = 1'b0;
  logic [15:0] sh = 16'd0;
  int nbits = 0, rise_cyc = 0, per_err = 0, dav_err = 0;
  int ld_act = 0, ndav = 0, cap_cyc = 0, dav_gap = 0;

  // Main-instance monitor: reassembles the word from DIN at each rising SCLK inside a CS-low window.
  always @(negedge clk) begin
    cyc   <= cyc + 1;
    sck_p <= dacsck;
    cs_p  <= daccs;
    dav_p <= davdac;
    if (davdac === 1'b1) begin
      ndav    <= ndav + 1;
      cap_cyc <= cyc;
      dav_gap <= cyc - cap_cyc;
      if (dav_p === 1'b1) dav_err <= dav_err + 1;
    end
    if (dacld !== LD_IDLE) ld_act <= ld_act + 1;
    if (cs_p === 1'b1 && daccs === 1'b0) begin
      nbits <= 0;
      sh    <= 16'd0;
    end else if (sck_p === 1'b0 && dacsck === 1'b1 && daccs === 1'b0) begin
      sh    <= {sh[14:0], dacout};
      nbits <= nbits + 1;
      if (nbits > 0 && (cyc - rise_cyc) != 2 * D0) per_err <= per_err + 1;
      rise_cyc <= cyc;
    end
    if (cs_p === 1'b0 && daccs === 1'b1 && nbits == 16) begin
      got_q.push_back(sh);
      gap_q.push_back(cyc - cap_cyc);
    end
  end

  logic sck1_p = 1'b0, cs1_p = 1'b1, ld1_p = LD_IDLE;
  int dav1_cyc = 0, dav1_gap = 0, ndav1 = 0, rises1 = 0, rise1_cyc = 0, per1_err = 0;
  int cs1_rise = 0, ld1_fall = 0, ld1_len = 0, ld1_evts = 0;

  // CLKDIV=1 instance monitor: timing of SCLK, CS and LDAC.
  always @(negedge clk) begin
    sck1_p <= dacsck1;
    cs1_p  <= daccs1;
    ld1_p  <= dacld1;
    if (davdac1 === 1'b1) begin
      ndav1    <= ndav1 + 1;
      dav1_cyc <= cyc;
      dav1_gap <= cyc - dav1_cyc;
    end
    if (cs1_p === 1'b1 && daccs1 === 1'b0) begin
      rises1 <= 0;
    end else if (sck1_p === 1'b0 && dacsck1 === 1'b1 && daccs1 === 1'b0) begin
      rises1 <= rises1 + 1;
      if (rises1 > 0 && (cyc - rise1_cyc) != 2 * D1) per1_err <= per1_err + 1;
      rise1_cyc <= cyc;
    end
    if (cs1_p === 1'b0 && daccs1 === 1'b1) cs1_rise <= cyc;
    if (dacld1 !== ld1_p) ld1_evts <= ld1_evts + 1;
    if (ld1_p === 1'b1 && dacld1 === 1'b0) ld1_fall <= cyc;
    if (ld1_p === 1'b0 && dacld1 === 1'b1) ld1_len <= cyc - ld1_fall;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input logic [15:0] exp_w);
    bit ok = 1'b0;
    data = w;
    dav  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (davdac === 1'b1) ok = 1'b1;
    end
    dav = 1'b0;
    n_tests++;
    if (ok) exp_q.push_back(exp_w);
    else begin
      n_fail++;
      $display("FAIL send_ack: no davdac for 0x%0h within 200 cycles", w);
    end
  endtask

  task automatic wait_frame(input string nm);
    int t = 0;
    while (got_q.size() == 0 && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: frame missing, got %0d frames expected %0d queued", nm, got_q.size(), exp_q.size());
    end else begin
      check({nm, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
      check({nm, "_cs_gap"}, 32'(gap_q.pop_front()), 32'(34 * D0));
    end
  endtask

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_word;
    int          exp_ld;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int ld0, n0, t;
    vecs[0] = '{din: 16'hA5C3, exp_word: 16'hA5C3, exp_ld: LDC * D0};
    vecs[1] = '{din: 16'h0000, exp_word: 16'h0000, exp_ld: LDC * D0};
    vecs[2] = '{din: 16'hFFFF, exp_word: 16'hFFFF, exp_ld: LDC * D0};
    vecs[3] = '{din: 16'h0001, exp_word: 16'h0001, exp_ld: LDC * D0};
    vecs[4] = '{din: 16'h8000, exp_word: 16'h8000, exp_ld: LDC * D0};
    vecs[5] = '{din: 16'h1234, exp_word: 16'h1234, exp_ld: LDC * D0};

    rst = 1'b1; dav = 1'b1; data = 16'hFFFF; dav1 = 1'b1; data1 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("reset_outputs", 32'({davdac, daccs, dacsck, dacout, dacld}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, LD_IDLE}));
    end
    check("reset_outputs_div1", 32'({davdac1, daccs1, dacsck1, dacout1, dacld1}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, LD_IDLE}));
    check("reset_no_capture", 32'(ndav), 32'd0);
    rst = 1'b0; dav = 1'b0; dav1 = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ld0 = ld_act;
      send(vecs[i].din, vecs[i].exp_word);
      wait_frame("table");
      repeat (3 * D0 + 4) @(negedge clk);
      #1;
      check("table_ldac_cycles", 32'(ld_act - ld0), 32'(vecs[i].exp_ld));
    end
    check("sck_period", 32'(per_err), 32'd0);

    for (int i = 1; i <= 4; i++) send(16'(i), 16'(i));
    for (int i = 0; i < 4; i++) wait_frame("handshake");
    check("handshake_spacing", 32'(dav_gap), 32'(FRAME0 + 1));

    n0 = ndav; data = 16'h8000; dav = 1'b1; t = 0;
    while ((ndav - n0) < 5 && t < 5 * (FRAME0 + 1) + 20) begin
      @(negedge clk); #1;
      t++;
      if (davdac === 1'b1) exp_q.push_back(16'h8000);
    end
    dav = 1'b0;
    check("stuck_ack_count", 32'(ndav - n0), 32'd5);
    for (int i = 0; i < 5; i++) wait_frame("stuck");
    repeat (FRAME0 + 5) @(negedge clk);
    #1;
    check("stuck_no_extra_ack", 32'(ndav - n0), 32'd5);
    check("stuck_spacing", 32'(dav_gap), 32'(FRAME0 + 1));
    check("ack_single_cycle", 32'(dav_err), 32'd0);

    send(16'h5A5A, 16'h5A5A);
    t = 0;
    while (nbits < 7 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("midrst_reached_bit7", 32'(nbits), 32'd7);
    ld0 = ld_act;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", 32'({daccs, dacsck, davdac}), 32'({1'b1, 1'b0, 1'b0}));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("midrst_no_ldac", 32'(ld_act - ld0), 32'd0);
    check("midrst_no_frame", 32'(got_q.size()), 32'd0);
    send(16'h0F0F, 16'h0F0F);
    wait_frame("after_rst");

    n0 = ndav1; data1 = 16'hC3A5; dav1 = 1'b1; t = 0;
    while ((ndav1 - n0) < 2 && t < 3 * (FRAME1 + 1) + 10) begin
      @(negedge clk); #1;
      t++;
    end
    dav1 = 1'b0;
    repeat (FRAME1 + 10) @(negedge clk);
    #1;
    check("div1_ack_count", 32'(ndav1 - n0), 32'd2);
    check("div1_frame_spacing", 32'(dav1_gap), 32'(FRAME1 + 1));
    check("div1_sck_rises", 32'(rises1), 32'd16);
    check("div1_sck_period", 32'(per1_err), 32'd0);
    check("div1_cs_gap", 32'(cs1_rise - dav1_cyc), 32'(34 * D1));
`ifdef DA3_LDAC_PULSE_EN
    check("div1_ldac_start", 32'(ld1_fall - cs1_rise), 32'(D1));
    check("div1_ldac_len", 32'(ld1_len), 32'(D1));
`else
    check("div1_ldac_static", 32'(ld1_evts), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
